// File: rtl/acc_multicycle_ctrl_pkg.sv
// Shared encodings for the accumulator multicycle controller: states, opcodes,
// datapath mux selects and the decoded control word.
package acc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH   = 5'd0,
        S_DECODE  = 5'd1,
        S_STK_RD  = 5'd2,
        S_STK_WR  = 5'd3,
        S_ALU     = 5'd4,
        S_ACC_WB  = 5'd5,
        S_BR_RES  = 5'd6,
        S_JAL     = 5'd7,
        S_JRA     = 5'd8,
        S_SP_ADJ  = 5'd9,
        S_ACC_RA  = 5'd10,
        S_RA_ACC  = 5'd11,
        S_ACC_IMM = 5'd12,
        S_HALT    = 5'd13,
        S_TRAP    = 5'd14
    } state_t;

    localparam logic [3:0] OP_ADD      = 4'd0;
    localparam logic [3:0] OP_SET      = 4'd1;
    localparam logic [3:0] OP_GET      = 4'd2;
    localparam logic [3:0] OP_ACCSETI  = 4'd3;
    localparam logic [3:0] OP_ADDI     = 4'd4;
    localparam logic [3:0] OP_SUB      = 4'd5;
    localparam logic [3:0] OP_BEQ      = 4'd6;
    localparam logic [3:0] OP_BNE      = 4'd7;
    localparam logic [3:0] OP_BLE      = 4'd8;
    localparam logic [3:0] OP_JAL      = 4'd9;
    localparam logic [3:0] OP_SPINIT   = 4'd10;
    localparam logic [3:0] OP_SPREL    = 4'd11;
    localparam logic [3:0] OP_JRA      = 4'd12;
    localparam logic [3:0] OP_ACCGETRA = 4'd13;
    localparam logic [3:0] OP_RAGETACC = 4'd14;
    localparam logic [3:0] OP_HALT     = 4'd15;

    localparam int NUM_OPS = 16;

    localparam logic [1:0] ASA_PC   = 2'd0;
    localparam logic [1:0] ASA_IMM  = 2'd2;
    localparam logic [1:0] ASA_ACC  = 2'd3;

    localparam logic [1:0] ASB_ONE  = 2'd0;
    localparam logic [1:0] ASB_OPB  = 2'd1;
    localparam logic [1:0] ASB_SP   = 2'd2;

    localparam logic [1:0] ACC_IMM  = 2'd0;
    localparam logic [1:0] ACC_RA   = 2'd1;
    localparam logic [1:0] ACC_MDR  = 2'd2;
    localparam logic [1:0] ACC_ALU  = 2'd3;

    localparam logic       RA_ACC   = 1'b0;
    localparam logic       RA_PC    = 1'b1;

    localparam logic [1:0] PC_BR    = 2'd0;
    localparam logic [1:0] PC_RA    = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] IORD_PC  = 2'd0;
    localparam logic [1:0] IORD_ALU = 2'd1;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;

    typedef struct packed {
        logic [1:0] asa_sel;
        logic [1:0] asb_sel;
        logic [2:0] alu_op;
        logic       acc_write;
        logic [1:0] acc_sel;
        logic       ra_write;
        logic       ra_sel;
        logic       mdr_write;
        logic       ir_write;
        logic       sp_write;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic [1:0] iord_sel;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    // First state after DECODE for a legal opcode.
    function automatic state_t decode_next(input logic [3:0] op);
        state_t nxt;
        case (op)
            OP_ADD, OP_SUB, OP_GET,
            OP_BEQ, OP_BNE, OP_BLE:  nxt = S_STK_RD;
            OP_SET:                  nxt = S_STK_WR;
            OP_ACCSETI:              nxt = S_ACC_IMM;
            OP_ADDI:                 nxt = S_ALU;
            OP_JAL:                  nxt = S_JAL;
            OP_SPINIT, OP_SPREL:     nxt = S_SP_ADJ;
            OP_JRA:                  nxt = S_JRA;
            OP_ACCGETRA:             nxt = S_ACC_RA;
            OP_RAGETACC:             nxt = S_RA_ACC;
            OP_HALT:                 nxt = S_HALT;
            default:                 nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/acc_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller side,
// slave = datapath side that supplies opcode, memory ready and compares.
interface acc_multicycle_ctrl_if #(
    parameter int OPCODE_W = 5,
    parameter int STATE_W  = 5,
    parameter int CNT_W    = 32
) ();
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                br_eq;
    logic                br_le;

    logic [1:0]          asa_sel;
    logic [1:0]          asb_sel;
    logic [2:0]          alu_op;
    logic                acc_write;
    logic [1:0]          acc_sel;
    logic                ra_write;
    logic                ra_sel;
    logic                mdr_write;
    logic                ir_write;
    logic                sp_write;
    logic                pc_write;
    logic [1:0]          pc_sel;
    logic [1:0]          iord_sel;
    logic                mem_read;
    logic                mem_write;

    logic [STATE_W-1:0]  state;
    logic                retired;
    logic [CNT_W-1:0]    instr_count;
    logic                halted;
    logic                trap;

    modport master (
        input  opcode, mem_ready, br_eq, br_le,
        output asa_sel, asb_sel, alu_op, acc_write, acc_sel, ra_write, ra_sel,
               mdr_write, ir_write, sp_write, pc_write, pc_sel, iord_sel,
               mem_read, mem_write, state, retired, instr_count, halted, trap
    );

    modport slave (
        output opcode, mem_ready, br_eq, br_le,
        input  asa_sel, asb_sel, alu_op, acc_write, acc_sel, ra_write, ra_sel,
               mdr_write, ir_write, sp_write, pc_write, pc_sel, iord_sel,
               mem_read, mem_write, state, retired, instr_count, halted, trap
    );
endinterface

// File: rtl/acc_multicycle_ctrl_branch_eval.sv
// Branch-taken decision for BEQ/BNE/BLE from the latched opcode and the
// datapath compare flags; every other opcode evaluates not-taken.
module acc_branch_eval
    import acc_ctrl_pkg::*;
(
    input  logic [3:0] op,
    input  logic       br_eq,
    input  logic       br_le,
    output logic       taken
);

    assign taken = ((op == OP_BEQ) &&  br_eq)
                 | ((op == OP_BNE) && !br_eq)
                 | ((op == OP_BLE) &&  br_le);

endmodule

// File: rtl/acc_multicycle_ctrl.sv
// Multicycle fetch/decode/execute sequencer for the 16-opcode accumulator ISA,
// with memory wait states, halt, sticky illegal-opcode trap and retire counter.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  FETCH     | read instruction at PC; on ready load IR, PC <= PC+1
//  DECODE    | ALUOut = SP+imm; latch opcode, dispatch
//  STK_RD    | read stack word at ALUOut into MDR (waits on mem_ready)
//  STK_WR    | write ACC to stack word at ALUOut (waits on mem_ready)
//  ALU       | ALUOut = ACC +/- MDR, or imm + operand for ADDI
//  ACC_WB    | ACC <= ALUOut, or MDR for GET
//  BR_RES    | conditional PC <= branch target
//  JAL       | RA <= PC, PC <= target
//  JRA       | PC <= RA
//  SP_ADJ    | SP update (SPINIT subtracts, SPREL adds)
//  ACC_RA    | ACC <= RA
//  RA_ACC    | RA <= ACC
//  ACC_IMM   | ACC <= imm
//  HALT      | absorbing until reset, halted=1
//  TRAP      | absorbing until reset, trap=1
module acc_multicycle_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int STATE_W  = 5,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    acc_multicycle_ctrl_if.master bus
);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       op_q;
    logic [3:0]       op_dec;
    logic             op_legal;
    logic             taken;
    logic             retire;
    logic [CNT_W-1:0] count_q;
    ctrl_t            ctrl;

    assign op_dec   = bus.opcode[3:0];
    assign op_legal = (bus.opcode < OPCODE_W'(NUM_OPS));

    acc_branch_eval u_branch_eval (
        .op    (op_q),
        .br_eq (bus.br_eq),
        .br_le (bus.br_le),
        .taken (taken)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= op_dec;
            end
            if (retire) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        unique case (state_q)
            S_FETCH: begin
                ctrl.iord_sel = IORD_PC;
                ctrl.mem_read = 1'b1;
                ctrl.asa_sel  = ASA_PC;
                ctrl.asb_sel  = ASB_ONE;
                ctrl.alu_op   = ALU_ADD;
                if (bus.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_sel   = PC_ALU;
                    state_d       = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.asa_sel = ASA_IMM;
                ctrl.asb_sel = ASB_SP;
                ctrl.alu_op  = ALU_ADD;
                state_d      = op_legal ? decode_next(op_dec) : S_TRAP;
            end
            S_STK_RD: begin
                ctrl.iord_sel = IORD_ALU;
                ctrl.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.mdr_write = 1'b1;
                    if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                        state_d = S_ALU;
                    end else if (op_q == OP_GET) begin
                        state_d = S_ACC_WB;
                    end else begin
                        state_d = S_BR_RES;
                    end
                end
            end
            S_STK_WR: begin
                ctrl.iord_sel  = IORD_ALU;
                ctrl.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_ALU: begin
                ctrl.asa_sel = (op_q == OP_ADDI) ? ASA_IMM : ASA_ACC;
                ctrl.asb_sel = ASB_OPB;
                ctrl.alu_op  = (op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
                state_d      = S_ACC_WB;
            end
            S_ACC_WB: begin
                ctrl.acc_write = 1'b1;
                ctrl.acc_sel   = (op_q == OP_GET) ? ACC_MDR : ACC_ALU;
                state_d        = S_FETCH;
            end
            S_BR_RES: begin
                ctrl.pc_sel   = PC_BR;
                ctrl.pc_write = taken;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                ctrl.ra_write = 1'b1;
                ctrl.ra_sel   = RA_PC;
                ctrl.pc_write = 1'b1;
                ctrl.pc_sel   = PC_BR;
                state_d       = S_FETCH;
            end
            S_JRA: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_sel   = PC_RA;
                state_d       = S_FETCH;
            end
            S_SP_ADJ: begin
                ctrl.sp_write = 1'b1;
                ctrl.alu_op   = (op_q == OP_SPINIT) ? ALU_SUB : ALU_ADD;
                state_d       = S_FETCH;
            end
            S_ACC_RA: begin
                ctrl.acc_write = 1'b1;
                ctrl.acc_sel   = ACC_RA;
                state_d        = S_FETCH;
            end
            S_RA_ACC: begin
                ctrl.ra_write = 1'b1;
                ctrl.ra_sel   = RA_ACC;
                state_d       = S_FETCH;
            end
            S_ACC_IMM: begin
                ctrl.acc_write = 1'b1;
                ctrl.acc_sel   = ACC_IMM;
                state_d        = S_FETCH;
            end
            S_HALT, S_TRAP: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // Reset is asynchronous, so strobes must also be masked combinationally.
        if (reset) begin
            ctrl    = '0;
            state_d = S_FETCH;
        end
    end

    // HALT retires on entry; TRAP never reaches FETCH or HALT so it never retires.
    assign retire = !reset
                  && (((state_d == S_FETCH) && (state_q != S_FETCH))
                   || ((state_d == S_HALT)  && (state_q != S_HALT)));

    assign bus.asa_sel     = ctrl.asa_sel;
    assign bus.asb_sel     = ctrl.asb_sel;
    assign bus.alu_op      = ctrl.alu_op;
    assign bus.acc_write   = ctrl.acc_write;
    assign bus.acc_sel     = ctrl.acc_sel;
    assign bus.ra_write    = ctrl.ra_write;
    assign bus.ra_sel      = ctrl.ra_sel;
    assign bus.mdr_write   = ctrl.mdr_write;
    assign bus.ir_write    = ctrl.ir_write;
    assign bus.sp_write    = ctrl.sp_write;
    assign bus.pc_write    = ctrl.pc_write;
    assign bus.pc_sel      = ctrl.pc_sel;
    assign bus.iord_sel    = ctrl.iord_sel;
    assign bus.mem_read    = ctrl.mem_read;
    assign bus.mem_write   = ctrl.mem_write;
    assign bus.state       = STATE_W'(state_q);
    assign bus.retired     = retire;
    assign bus.instr_count = count_q;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.trap        = (state_q == S_TRAP);

endmodule

// File: tb/tb_acc_multicycle_ctrl.sv
// Randomized self-checking bench: each instruction is expanded into a
// per-cycle expectation plan from the ISA timing rules, then replayed.
module tb_acc_multicycle_ctrl;
    import acc_ctrl_pkg::*;

    localparam int CW = 4;

    localparam logic [8:0] B_MR   = 9'h100;
    localparam logic [8:0] B_MW   = 9'h080;
    localparam logic [8:0] B_IRW  = 9'h040;
    localparam logic [8:0] B_PCW  = 9'h020;
    localparam logic [8:0] B_MDRW = 9'h010;
    localparam logic [8:0] B_ACCW = 9'h008;
    localparam logic [8:0] B_RAW  = 9'h004;
    localparam logic [8:0] B_SPW  = 9'h002;
    localparam logic [8:0] B_RET  = 9'h001;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    acc_multicycle_ctrl_if #(.OPCODE_W(5), .STATE_W(5), .CNT_W(CW)) bus ();

    acc_multicycle_ctrl #(.OPCODE_W(5), .STATE_W(5), .CNT_W(CW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk     = 0;
    int n_err     = 0;
    int model_cnt = 0;

    typedef struct {
        logic       rdy;
        logic [8:0] strb;
        state_t     st;
        logic [1:0] asel;
        logic [1:0] psel;
        logic       ca;
        logic [2:0] aop;
        logic       dec;
    } cyc_t;

    cyc_t plan[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] obs_strobes();
        return {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.mdr_write,
                bus.acc_write, bus.ra_write, bus.sp_write, bus.retired};
    endfunction

    function automatic logic rbit();
        return ($urandom % 2) == 1;
    endfunction

    task automatic add_cyc(input logic rdy, input logic [8:0] s, input state_t st,
                           input logic [1:0] asel, input logic [1:0] psel,
                           input logic ca, input logic [2:0] aop, input logic dec);
        cyc_t c;
        c.rdy = rdy; c.strb = s; c.st = st; c.asel = asel;
        c.psel = psel; c.ca = ca; c.aop = aop; c.dec = dec;
        plan.push_back(c);
    endtask

    task automatic add_mem(input state_t st, input int w, input logic [8:0] wait_s,
                           input logic [8:0] done_s, input logic [1:0] psel, input logic ca);
        for (int i = 0; i < w; i++) add_cyc(1'b0, wait_s, st, 2'd0, psel, ca, 3'd0, 1'b0);
        add_cyc(1'b1, done_s, st, 2'd0, psel, ca, 3'd0, 1'b0);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from the ISA rules.
    task automatic build(input int op, input logic eq, input logic le, input int fw, input int mw);
        logic taken;
        int   w;
        plan.delete();
        w = (fw >= 0) ? fw : int'($urandom_range(mw, 0));
        add_mem(S_FETCH, w, B_MR, B_MR | B_IRW | B_PCW, 2'd2, 1'b1);
        add_cyc(rbit(), (op == 15) ? B_RET : 9'h0, S_DECODE, 2'd0, 2'd0, 1'b1, 3'd0, 1'b1);
        w = int'($urandom_range(mw, 0));
        case (op)
            0, 5: begin
                add_mem(S_STK_RD, w, B_MR, B_MR | B_MDRW, 2'd0, 1'b0);
                add_cyc(rbit(), 9'h0, S_ALU, 2'd0, 2'd0, 1'b1, (op == 5) ? 3'd1 : 3'd0, 1'b0);
                add_cyc(rbit(), B_ACCW | B_RET, S_ACC_WB, 2'd3, 2'd0, 1'b0, 3'd0, 1'b0);
            end
            2: begin
                add_mem(S_STK_RD, w, B_MR, B_MR | B_MDRW, 2'd0, 1'b0);
                add_cyc(rbit(), B_ACCW | B_RET, S_ACC_WB, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0);
            end
            1: add_mem(S_STK_WR, w, B_MW, B_MW | B_RET, 2'd0, 1'b0);
            3: add_cyc(rbit(), B_ACCW | B_RET, S_ACC_IMM, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0);
            4: begin
                add_cyc(rbit(), 9'h0, S_ALU, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0);
                add_cyc(rbit(), B_ACCW | B_RET, S_ACC_WB, 2'd3, 2'd0, 1'b0, 3'd0, 1'b0);
            end
            6, 7, 8: begin
                taken = ((op == 6) && eq) || ((op == 7) && !eq) || ((op == 8) && le);
                add_mem(S_STK_RD, w, B_MR, B_MR | B_MDRW, 2'd0, 1'b0);
                add_cyc(rbit(), B_RET | (taken ? B_PCW : 9'h0), S_BR_RES, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0);
            end
            9:      add_cyc(rbit(), B_RAW | B_PCW | B_RET, S_JAL, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0);
            10, 11: add_cyc(rbit(), B_SPW | B_RET, S_SP_ADJ, 2'd0, 2'd0, 1'b1, (op == 10) ? 3'd1 : 3'd0, 1'b0);
            12:     add_cyc(rbit(), B_PCW | B_RET, S_JRA, 2'd0, 2'd1, 1'b0, 3'd0, 1'b0);
            13:     add_cyc(rbit(), B_ACCW | B_RET, S_ACC_RA, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0);
            14:     add_cyc(rbit(), B_RAW | B_RET, S_RA_ACC, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0);
            15: for (int i = 0; i < 5; i++) add_cyc(rbit(), 9'h0, S_HALT, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0);
            default: for (int i = 0; i < 10; i++) add_cyc(rbit(), 9'h0, S_TRAP, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0);
        endcase
    endtask

    // Opcode is valid only in DECODE; other cycles see random IR contents.
    task automatic run(input int op, input logic eq, input logic le);
        bus.br_eq = eq;
        bus.br_le = le;
        foreach (plan[i]) begin
            @(negedge clk);
            bus.mem_ready = plan[i].rdy;
            bus.opcode    = plan[i].dec ? 5'(op) : 5'($urandom);
            #1;
            chk("strobes", 32'(obs_strobes()), 32'(plan[i].strb));
            chk("state", 32'(bus.state), 32'(plan[i].st));
            if ((plan[i].strb & B_ACCW) != 9'h0) chk("acc_sel", 32'(bus.acc_sel), 32'(plan[i].asel));
            if ((plan[i].strb & B_PCW) != 9'h0)  chk("pc_sel", 32'(bus.pc_sel), 32'(plan[i].psel));
            if (plan[i].ca) chk("alu_op", 32'(bus.alu_op), 32'(plan[i].aop));
            chk("halted", 32'(bus.halted), 32'(plan[i].st == S_HALT));
            chk("trap", 32'(bus.trap), 32'(plan[i].st == S_TRAP));
            if ((plan[i].strb & B_RET) != 9'h0) model_cnt = (model_cnt + 1) % (1 << CW);
        end
        @(posedge clk);
        #1;
        chk("instr_count", 32'(bus.instr_count), 32'(model_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_strobes", 32'(obs_strobes()), 32'd0);
        chk("rst_selects", 32'({bus.asa_sel, bus.asb_sel, bus.alu_op, bus.acc_sel,
                                bus.ra_sel, bus.pc_sel, bus.iord_sel}), 32'd0);
        chk("rst_state", 32'(bus.state), 32'(S_FETCH));
        chk("rst_count", 32'(bus.instr_count), 32'd0);
        chk("rst_flags", 32'({bus.halted, bus.trap}), 32'd0);
        @(negedge clk);
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        model_cnt     = 0;
    endtask

    initial begin
        int   op;
        logic eq, le;
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        bus.br_eq     = 1'b0;
        bus.br_le     = 1'b0;

        do_reset();

        build(0, 1'b0, 1'b0, 0, 0);  run(0, 1'b0, 1'b0);
        build(3, 1'b0, 1'b0, 3, 0);  run(3, 1'b0, 1'b0);
        build(7, 1'b1, 1'b0, 0, 0);  run(7, 1'b1, 1'b0);
        build(7, 1'b0, 1'b0, 0, 0);  run(7, 1'b0, 1'b0);
        build(8, 1'b0, 1'b1, 0, 0);  run(8, 1'b0, 1'b1);
        build(6, 1'b1, 1'b0, 0, 0);  run(6, 1'b1, 1'b0);
        build(8, 1'b1, 1'b0, 0, 0);  run(8, 1'b1, 1'b0);

        repeat (120) begin
            op = int'($urandom_range(14, 0));
            eq = rbit();
            le = rbit();
            build(op, eq, le, -1, 3);
            run(op, eq, le);
        end

        do_reset();
        repeat (16) begin
            build(3, 1'b0, 1'b0, 0, 0);
            run(3, 1'b0, 1'b0);
        end
        build(15, 1'b0, 1'b0, 0, 0);  run(15, 1'b0, 1'b0);

        do_reset();
        build(20, 1'b0, 1'b0, 0, 0);  run(20, 1'b0, 1'b0);
        do_reset();

        // Reset while STK_WR is waiting on memory.
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.opcode    = 5'($urandom);
        #1 chk("t5_fetch", 32'(bus.state), 32'(S_FETCH));
        @(negedge clk);
        bus.opcode    = 5'd1;
        #1 chk("t5_decode", 32'(bus.state), 32'(S_DECODE));
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.opcode    = 5'($urandom);
        #1;
        chk("t5_wr_wait", 32'(bus.mem_write), 32'd1);
        chk("t5_wr_state", 32'(bus.state), 32'(S_STK_WR));
        #2 reset = 1'b1;
        #1;
        chk("t5_wr_drop", 32'(obs_strobes()), 32'd0);
        chk("t5_rst_state", 32'(bus.state), 32'(S_FETCH));
        @(negedge clk);
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        model_cnt     = 0;
        #1;
        chk("t5_release", 32'(obs_strobes()), 32'(B_MR));
        chk("t5_rel_state", 32'(bus.state), 32'(S_FETCH));
        build(4, 1'b0, 1'b0, 1, 2);   run(4, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
